// File: rtl/dual_port_ram.sv
// True dual-port byte-writable word RAM. A clear sweep zero-fills the array
// after reset, and reads have a configurable latency and read-during-write mode.
module dual_port_ram #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    DEPTH          = 2048,
    parameter int    ADDR_WIDTH     = $clog2(DEPTH),
    parameter int    READ_LATENCY   = 1,
    parameter int    WRITE_MODE     = 0,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string BOOT_FILE      = ""
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    ready,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_wb,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_data_in,
    output logic [DATA_WIDTH-1:0]   a_data_out,
    output logic                    a_valid,
    input  logic                    b_en,
    input  logic [DATA_WIDTH/8-1:0] b_wb,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_data_in,
    output logic [DATA_WIDTH-1:0]   b_data_out,
    output logic                    b_valid
);
    localparam int NB = DATA_WIDTH / 8;
    localparam bit SWEEP_EN = (CLEAR_ON_RESET != 0) && (BOOT_FILE == "");
    localparam bit WRITE_FIRST = (WRITE_MODE == 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [ADDR_WIDTH-1:0]   r_count;
    logic [ADDR_WIDTH-1:0]   w_countNext;
    logic                    r_ready;
    logic                    w_sweepWr;
    logic                    w_accA;
    logic                    w_accB;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [DATA_WIDTH-1:0]   w_aOld;
    logic [DATA_WIDTH-1:0]   w_bOld;
    logic [DATA_WIDTH-1:0]   w_aMerge;
    logic [DATA_WIDTH-1:0]   w_bMerge;
    logic [DATA_WIDTH-1:0]   w_aRead;
    logic [DATA_WIDTH-1:0]   w_bRead;

    logic                    r_aValid1;
    logic                    r_bValid1;
    logic [DATA_WIDTH-1:0]   r_aData1;
    logic [DATA_WIDTH-1:0]   r_bData1;

    // ready is registered so it rises on the same edge that finishes the sweep
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= SWEEP_EN ? INIT : RUN;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_ready <= (w_stateNext == RUN);
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        if (r_state == INIT) begin
            w_countNext = r_count + 1'b1;
            if (r_count == LAST_ADDR) begin
                w_stateNext = RUN;
            end
        end
    end

    always_comb begin
        w_sweepWr = 1'b0;
        w_accA    = 1'b0;
        w_accB    = 1'b0;
        if (reset) begin
            if (r_state == INIT) begin
                w_sweepWr = 1'b1;
            end else if (r_ready) begin
                w_accA = a_en;
                w_accB = b_en;
            end
        end
    end

    assign ready = r_ready;

    // Port A bytes are written last so they win a same-address collision
    always_ff @(posedge clock) begin
        if (w_sweepWr) begin
            r_mem[r_count] <= '0;
        end
        for (int i = 0; i < NB; i++) begin
            if (w_accB && b_wb[i]) begin
                r_mem[b_addr][8*i +: 8] <= b_data_in[8*i +: 8];
            end
            if (w_accA && a_wb[i]) begin
                r_mem[a_addr][8*i +: 8] <= a_data_in[8*i +: 8];
            end
        end
    end

    assign w_aOld = r_mem[a_addr];
    assign w_bOld = r_mem[b_addr];

    // Write-first merges only the port's own bytes; the other port's write stays invisible
    always_comb begin
        w_aMerge = w_aOld;
        w_bMerge = w_bOld;
        for (int i = 0; i < NB; i++) begin
            if (a_wb[i]) begin
                w_aMerge[8*i +: 8] = a_data_in[8*i +: 8];
            end
            if (b_wb[i]) begin
                w_bMerge[8*i +: 8] = b_data_in[8*i +: 8];
            end
        end
    end

    assign w_aRead = WRITE_FIRST ? w_aMerge : w_aOld;
    assign w_bRead = WRITE_FIRST ? w_bMerge : w_bOld;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_aValid1 <= 1'b0;
            r_bValid1 <= 1'b0;
            r_aData1  <= '0;
            r_bData1  <= '0;
        end else begin
            r_aValid1 <= w_accA;
            r_bValid1 <= w_accB;
            if (w_accA) begin
                r_aData1 <= w_aRead;
            end
            if (w_accB) begin
                r_bData1 <= w_bRead;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_aValid2;
        logic                  r_bValid2;
        logic [DATA_WIDTH-1:0] r_aData2;
        logic [DATA_WIDTH-1:0] r_bData2;

        always_ff @(posedge clock) begin
            if (!reset) begin
                r_aValid2 <= 1'b0;
                r_bValid2 <= 1'b0;
                r_aData2  <= '0;
                r_bData2  <= '0;
            end else begin
                r_aValid2 <= r_aValid1;
                r_bValid2 <= r_bValid1;
                if (r_aValid1) begin
                    r_aData2 <= r_aData1;
                end
                if (r_bValid1) begin
                    r_bData2 <= r_bData1;
                end
            end
        end

        assign a_valid    = r_aValid2;
        assign b_valid    = r_bValid2;
        assign a_data_out = r_aData2;
        assign b_data_out = r_bData2;
    end else begin : g_lat1
        assign a_valid    = r_aValid1;
        assign b_valid    = r_bValid1;
        assign a_data_out = r_aData1;
        assign b_data_out = r_bData1;
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: two instances (latency 1 read-first, latency 2
// write-first) share stimulus and are compared with a word-level memory model.
module tb_dual_port_ram;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MAXC  = 4096;

    logic          clock;
    logic          reset;
    logic          aEn, bEn;
    logic [3:0]    aWb, bWb;
    logic [AW-1:0] aAddr, bAddr;
    logic [DW-1:0] aDin, bDin;

    logic          readyOut [2];
    logic          aValid   [2];
    logic          bValid   [2];
    logic [DW-1:0] aData    [2];
    logic [DW-1:0] bData    [2];

    dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(1), .WRITE_MODE(0),
                    .CLEAR_ON_RESET(1)) dut0 (
        .clock(clock), .reset(reset), .ready(readyOut[0]),
        .a_en(aEn), .a_wb(aWb), .a_addr(aAddr), .a_data_in(aDin),
        .a_data_out(aData[0]), .a_valid(aValid[0]),
        .b_en(bEn), .b_wb(bWb), .b_addr(bAddr), .b_data_in(bDin),
        .b_data_out(bData[0]), .b_valid(bValid[0]));

    dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(2), .WRITE_MODE(1),
                    .CLEAR_ON_RESET(1)) dut1 (
        .clock(clock), .reset(reset), .ready(readyOut[1]),
        .a_en(aEn), .a_wb(aWb), .a_addr(aAddr), .a_data_in(aDin),
        .a_data_out(aData[1]), .a_valid(aValid[1]),
        .b_en(bEn), .b_wb(bWb), .b_addr(bAddr), .b_data_in(bDin),
        .b_data_out(bData[1]), .b_valid(bValid[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: word array, sweep countdown, per-cycle read history
    logic [DW-1:0] modelMem [DEPTH];
    int            sweepLeft     = DEPTH;
    bit            modelReady    = 1'b0;
    int            cycleNo       = 0;
    int            lastResetEdge = 0;
    bit            histAccA [MAXC];
    bit            histAccB [MAXC];
    logic [DW-1:0] histRdA  [2][MAXC];
    logic [DW-1:0] histRdB  [2][MAXC];
    logic [DW-1:0] lastA    [2];
    logic [DW-1:0] lastB    [2];
    int            latency  [2] = '{1, 2};

    typedef struct {
        bit          aEn;
        logic [3:0]  aWb;
        logic [3:0]  aAddr;
        logic [31:0] aDin;
        bit          bEn;
        logic [3:0]  bWb;
        logic [3:0]  bAddr;
        logic [31:0] bDin;
        bit          chkA;
        logic [31:0] expA0;
        logic [31:0] expA1;
        bit          chkB;
        logic [31:0] expB0;
        logic [31:0] expB1;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] wb);
        logic [31:0] mask;
        mask = {{8{wb[3]}}, {8{wb[2]}}, {8{wb[1]}}, {8{wb[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit ae, input logic [3:0] awb, input logic [3:0] aad,
                                 input logic [31:0] ad, input bit be, input logic [3:0] bwb,
                                 input logic [3:0] bad, input logic [31:0] bd);
        aEn = ae; aWb = awb; aAddr = aad; aDin = ad;
        bEn = be; bWb = bwb; bAddr = bad; bDin = bd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    // Advance the model by one edge, clock the DUTs, then compare every output
    task automatic step();
        logic [31:0] oldA, oldB;
        cycleNo++;
        histAccA[cycleNo] = 1'b0;
        histAccB[cycleNo] = 1'b0;
        if (!reset) begin
            lastResetEdge = cycleNo;
            sweepLeft     = DEPTH;
            modelReady    = 1'b0;
            for (int d = 0; d < 2; d++) begin
                lastA[d] = '0;
                lastB[d] = '0;
            end
        end else if (modelReady) begin
            oldA = modelMem[aAddr];
            oldB = modelMem[bAddr];
            if (aEn) begin
                histAccA[cycleNo]   = 1'b1;
                histRdA[0][cycleNo] = oldA;
                histRdA[1][cycleNo] = merge(oldA, aDin, aWb);
            end
            if (bEn) begin
                histAccB[cycleNo]   = 1'b1;
                histRdB[0][cycleNo] = oldB;
                histRdB[1][cycleNo] = merge(oldB, bDin, bWb);
            end
            if (bEn) modelMem[bAddr] = merge(modelMem[bAddr], bDin, bWb);
            if (aEn) modelMem[aAddr] = merge(modelMem[aAddr], aDin, aWb);
        end else if (sweepLeft > 0) begin
            modelMem[DEPTH - sweepLeft] = '0;
            sweepLeft--;
            if (sweepLeft == 0) modelReady = 1'b1;
        end
        @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            int src;
            bit evA, evB;
            src = cycleNo - latency[d] + 1;
            evA = (src > lastResetEdge) && histAccA[src];
            evB = (src > lastResetEdge) && histAccB[src];
            if (evA) lastA[d] = histRdA[d][src];
            if (evB) lastB[d] = histRdB[d][src];
            checkOutput($sformatf("dut%0d.ready", d), 32'(readyOut[d]), 32'(modelReady));
            checkOutput($sformatf("dut%0d.a_valid", d), 32'(aValid[d]), 32'(evA));
            checkOutput($sformatf("dut%0d.b_valid", d), 32'(bValid[d]), 32'(evB));
            checkOutput($sformatf("dut%0d.a_data_out", d), aData[d], lastA[d]);
            checkOutput($sformatf("dut%0d.b_data_out", d), bData[d], lastB[d]);
        end
    endtask

    task automatic waitReady(input string name, input int required);
        int cnt;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (readyOut[0] !== 1'b1 && cnt < 100);
        checkOutput(name, 32'(cnt), 32'(required));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        for (int d = 0; d < 2; d++) begin
            lastA[d] = '0;
            lastB[d] = '0;
        end
        reset = 1'b0;
        idle();
        repeat (3) step();

        // Sweep after first release, with a write pending during INIT
        reset = 1'b1;
        applyStimulus(1'b1, 4'hF, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'hF, 4'd1, 32'hFFFF_FFFF);
        waitReady("sweepReadyCycles", DEPTH);
        idle();

        // Fill with all-ones, then reset and check the sweep clears it
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 4'hF, 4'(i), 32'hFFFF_FFFF, 1'b0, 4'h0, 4'h0, 32'h0);
            step();
        end
        idle();
        step();
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        waitReady("resweepReadyCycles", DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
            step();
            checkOutput("sweepZeroA", aData[0], 32'h0);
            checkOutput("sweepZeroB", bData[0], 32'h0);
        end
        idle();
        step();
        step();

        // Directed vectors: byte merge, read-during-write, collision, cross-port
        vecs[0] = '{1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'h0, 4'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 4'h5, 4'd5, 32'hAABB_CCDD, 1'b0, 4'h0, 4'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0,
                    1'b1, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 4'hF, 4'd3, 32'h0000_0001, 1'b0, 4'h0, 4'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 4'hF, 4'd3, 32'h0000_0002, 1'b0, 4'h0, 4'd0, 32'h0,
                    1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 4'h3, 4'd7, 32'hAAAA_AAAA, 1'b1, 4'hF, 4'd7, 32'hBBBB_BBBB,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0,
                    1'b1, 32'hBBBB_AAAA, 32'hBBBB_AAAA, 1'b1, 32'hBBBB_AAAA, 32'hBBBB_AAAA};
        vecs[7] = '{1'b1, 4'hF, 4'd9, 32'h0000_0004, 1'b0, 4'h0, 4'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[8] = '{1'b1, 4'hF, 4'd9, 32'h0000_0005, 1'b1, 4'h0, 4'd9, 32'h0,
                    1'b1, 32'h0000_0004, 32'h0000_0005, 1'b1, 32'h0000_0004, 32'h0000_0004};
        vecs[9] = '{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0005, 32'h0000_0005};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].aEn, vecs[i].aWb, vecs[i].aAddr, vecs[i].aDin,
                          vecs[i].bEn, vecs[i].bWb, vecs[i].bAddr, vecs[i].bDin);
            step();
            idle();
            checkOutput($sformatf("vec%0d.lat1.a_valid", i), 32'(aValid[0]), 32'(vecs[i].aEn));
            checkOutput($sformatf("vec%0d.lat2.a_valid.early", i), 32'(aValid[1]), 32'h0);
            if (vecs[i].chkA) checkOutput($sformatf("vec%0d.lat1.a_data", i), aData[0], vecs[i].expA0);
            if (vecs[i].chkB) checkOutput($sformatf("vec%0d.lat1.b_data", i), bData[0], vecs[i].expB0);
            step();
            checkOutput($sformatf("vec%0d.lat2.a_valid", i), 32'(aValid[1]), 32'(vecs[i].aEn));
            checkOutput($sformatf("vec%0d.lat1.a_valid.late", i), 32'(aValid[0]), 32'h0);
            if (vecs[i].chkA) checkOutput($sformatf("vec%0d.lat2.a_data", i), aData[1], vecs[i].expA1);
            if (vecs[i].chkB) checkOutput($sformatf("vec%0d.lat2.b_data", i), bData[1], vecs[i].expB1);
        end

        // Cross-port write then immediate next-cycle read
        applyStimulus(1'b1, 4'hF, 4'd9, 32'h0000_0006, 1'b1, 4'h0, 4'd9, 32'h0);
        step();
        checkOutput("xport.sameCycle.lat1", bData[0], 32'h0000_0005);
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
        step();
        checkOutput("xport.nextCycle.lat1", bData[0], 32'h0000_0006);
        checkOutput("xport.sameCycle.lat2", bData[1], 32'h0000_0005);
        idle();
        step();
        checkOutput("xport.nextCycle.lat2", bData[1], 32'h0000_0006);

        // Randomised traffic, biased towards a few addresses to provoke collisions
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15)),
                          $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15)),
                          $urandom);
            step();
        end
        idle();
        step();
        step();

        // Reset mid-sweep at counter 8 restarts the sweep
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (8) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        waitReady("midSweepReadyCycles", DEPTH);

        // Reset with a latency-2 read still in flight
        applyStimulus(1'b1, 4'hF, 4'd2, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0, 32'h0);
        step();
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        step();
        checkOutput("inflight.lat1.a_data", aData[0], 32'hDEAD_BEEF);
        idle();
        reset = 1'b0;
        step();
        checkOutput("inflight.lat2.a_valid", 32'(aValid[1]), 32'h0);
        checkOutput("inflight.lat2.a_data", aData[1], 32'h0);
        step();
        checkOutput("inflight.lat2.a_valid.after", 32'(aValid[1]), 32'h0);
        reset = 1'b1;
        waitReady("finalReadyCycles", DEPTH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
